cu_read_command_arbiter: RTL and testbench

- Shares the single AFU read-command buffer among NUM_REQ compute-unit command sources (edge job controls, vertex job controls).
- Arbitration is round-robin; each source is limited to MAX_OUTSTANDING in-flight reads.
- Each read response is routed back to its source by the cmd.cu_id field.
- A drain handshake stops new grants and reports when all in-flight reads have returned.

---
 rtl/cu_read_command_arbiter_if.sv | 53 +++++
 rtl/cu_read_command_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cu_read_command_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_read_command_arbiter_if.sv
// Shared types and the request/response bus bundle for cu_read_command_arbiter.
// The arbiter takes the slave modport; the compute-unit side takes the master modport.
package cu_arb_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cu_id;
    logic [31:0] address;
    logic [7:0]  size;
  } CommandBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic [7:0] cu_id;
    logic [7:0] tag;
  } ResponseCmd;

  typedef struct packed {
    logic        valid;
    ResponseCmd  cmd;
    logic [31:0] data;
  } ResponseBufferLine;

endpackage

interface cu_read_command_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  cu_arb_pkg::CommandBufferLine [NUM_REQ-1:0] command_in;
  cu_arb_pkg::BufferStatus                    read_buffer_status;
  cu_arb_pkg::ResponseBufferLine              read_response_in;
  logic [NUM_REQ-1:0]                         grant_out;
  cu_arb_pkg::CommandBufferLine               command_out;
  logic [NUM_REQ-1:0]                         response_valid_out;
  logic [NUM_REQ-1:0][7:0]                    outstanding_out;

  modport master (
    output command_in, read_buffer_status, read_response_in,
    input  grant_out, command_out, response_valid_out, outstanding_out
  );

  modport slave (
    input  command_in, read_buffer_status, read_response_in,
    output grant_out, command_out, response_valid_out, outstanding_out
  );

endinterface

// File: rtl/cu_read_command_arbiter.sv
// Round-robin arbiter sharing the AFU read-command buffer among NUM_REQ compute units,
// with per-port in-flight limits, response routing and drain. Optional stats: CU_ARB_STATS_EN.
module cu_read_command_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CU_ID_BASE      = 1
) (
  input  logic clock,
  input  logic rstn,
  input  logic enabled,
  input  logic drain_req,
  cu_read_command_arbiter_if.slave bus,
  output logic drain_done,
  output logic error_out
`ifdef CU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] grant_count_out,
  output logic [31:0]              stall_cycles_out
`endif
);
  import cu_arb_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);
  localparam logic [7:0] ID_BASE = 8'(CU_ID_BASE);
  localparam logic [8:0] ID_END  = 9'(CU_ID_BASE + NUM_REQ);

  localparam logic [1:0] ARB_RESET  = 2'd0;
  localparam logic [1:0] ARB_ACTIVE = 2'd1;
  localparam logic [1:0] ARB_DRAIN  = 2'd2;
  localparam logic [1:0] ARB_DONE   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [PTR_W-1:0]        rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0][7:0] outstanding_q, outstanding_d;
  CommandBufferLine        commandOut_q, commandOut_d;
  logic [NUM_REQ-1:0]      rspValid_q, rspValid_d;
  logic                    error_q, error_d;

  logic [NUM_REQ-1:0] eligible, grant, reqValid;
  logic               grantAny;
  logic [PTR_W-1:0]   grantIdx;
  logic [7:0]         rspOffset;
  logic [PTR_W-1:0]   rspIdx;
  logic               rspInRange, rspAccept, rspError, allIdle;
  logic               unusedInputs;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValid[i] = bus.command_in[i].valid;
      eligible[i] = reqValid[i] && (outstanding_q[i] < MAX_CNT) && (state_q == ARB_ACTIVE)
                    && !drain_req && !bus.read_buffer_status.alfull && enabled;
    end
  end

  // Search starts at rrPtr_q and wraps, so the port after the last winner has top priority.
  always_comb begin
    int idx;
    grantAny = 1'b0;
    grantIdx = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grantAny && eligible[idx]) begin
        grantAny = 1'b1;
        grantIdx = PTR_W'(idx);
      end
    end
    grant = grantAny ? (NUM_REQ'(1) << grantIdx) : '0;
  end

  always_comb begin
    rspOffset  = bus.read_response_in.cmd.cu_id - ID_BASE;
    rspIdx     = rspOffset[PTR_W-1:0];
    rspInRange = (bus.read_response_in.cmd.cu_id >= ID_BASE)
                 && ({1'b0, bus.read_response_in.cmd.cu_id} < ID_END);
    rspAccept  = bus.read_response_in.valid && rspInRange && (outstanding_q[rspIdx] != 8'd0);
    rspError   = bus.read_response_in.valid && !rspAccept;
    allIdle    = (outstanding_q == '0);
  end

  always_comb begin
    state_d       = state_q;
    rrPtr_d       = rrPtr_q;
    outstanding_d = outstanding_q;
    commandOut_d  = commandOut_q;
    rspValid_d    = rspValid_q;
    error_d       = error_q;
    if (enabled) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], rspAccept && (rspIdx == PTR_W'(i))})
          2'b10:   outstanding_d[i] = outstanding_q[i] + 8'd1;
          2'b01:   outstanding_d[i] = outstanding_q[i] - 8'd1;
          default: outstanding_d[i] = outstanding_q[i];
        endcase
      end
      if (grantAny) begin
        rrPtr_d            = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
        commandOut_d       = bus.command_in[grantIdx];
        commandOut_d.valid = 1'b1;
      end else begin
        commandOut_d.valid = 1'b0;
      end
      rspValid_d = rspAccept ? (NUM_REQ'(1) << rspIdx) : '0;
      error_d    = error_q | rspError;
      case (state_q)
        ARB_RESET:  state_d = ARB_ACTIVE;
        ARB_ACTIVE: if (drain_req) state_d = ARB_DRAIN;
        ARB_DRAIN:  begin
          if (!drain_req)   state_d = ARB_ACTIVE;
          else if (allIdle) state_d = ARB_DONE;
        end
        ARB_DONE:   if (!drain_req) state_d = ARB_ACTIVE;
        default:    state_d = ARB_RESET;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rstn) begin
      state_q       <= ARB_RESET;
      rrPtr_q       <= '0;
      outstanding_q <= '0;
      commandOut_q  <= '0;
      rspValid_q    <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rrPtr_q       <= rrPtr_d;
      outstanding_q <= outstanding_d;
      commandOut_q  <= commandOut_d;
      rspValid_q    <= rspValid_d;
      error_q       <= error_d;
    end
  end

`ifdef CU_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grantCount_q;
  logic [31:0]              stall_q;

  always_ff @(posedge clock) begin
    if (rstn) begin
      grantCount_q <= '0;
      stall_q      <= '0;
    end else if (enabled) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) grantCount_q[i] <= grantCount_q[i] + 32'd1;
      end
      if ((|reqValid) && bus.read_buffer_status.alfull) stall_q <= stall_q + 32'd1;
    end
  end

  assign grant_count_out  = grantCount_q;
  assign stall_cycles_out = stall_q;
`endif

  assign unusedInputs = ^{bus.read_buffer_status.full, bus.read_buffer_status.empty,
                          bus.read_response_in.cmd.tag, bus.read_response_in.data,
                          rspOffset[7:PTR_W], reqValid};

  assign bus.grant_out          = grant;
  assign bus.command_out        = commandOut_q;
  assign bus.response_valid_out = rspValid_q;
  assign bus.outstanding_out    = outstanding_q;
  assign drain_done             = (state_q == ARB_DONE);
  assign error_out              = error_q;

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Directed, table-driven bench for cu_read_command_arbiter; a second instance with
// MAX_OUTSTANDING=2 covers the in-flight limit.
module tb_cu_read_command_arbiter;
  import cu_arb_pkg::*;

  logic clock = 1'b0;
  logic rstn, enabled, drainReq;
  logic drainDone, errorOut, drainDoneL, errorOutL;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  cu_read_command_arbiter_if #(.NUM_REQ(4)) bus ();
  cu_read_command_arbiter_if #(.NUM_REQ(4)) busL ();

`ifdef CU_ARB_STATS_EN
  logic [3:0][31:0] grantCount, grantCountL;
  logic [31:0]      stallCycles, stallCyclesL;
`endif

  cu_read_command_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(16), .CU_ID_BASE(1)) dut (
    .clock(clock), .rstn(rstn), .enabled(enabled), .drain_req(drainReq),
    .bus(bus), .drain_done(drainDone), .error_out(errorOut)
`ifdef CU_ARB_STATS_EN
    , .grant_count_out(grantCount), .stall_cycles_out(stallCycles)
`endif
  );

  cu_read_command_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(2), .CU_ID_BASE(1)) dutLim (
    .clock(clock), .rstn(rstn), .enabled(enabled), .drain_req(1'b0),
    .bus(busL), .drain_done(drainDoneL), .error_out(errorOutL)
`ifdef CU_ARB_STATS_EN
    , .grant_count_out(grantCountL), .stall_cycles_out(stallCyclesL)
`endif
  );

  typedef struct {
    logic [3:0]  valid;
    logic        alfull;
    logic        rspV;
    logic [7:0]  rspCu;
    logic [3:0]  expGrant;
    logic        expCmdV;
    logic [31:0] expAddr;
    logic [3:0]  expRsp;
    logic        expErr;
    logic [31:0] expCnt;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic alfull,
                               input logic rspV, input logic [7:0] rspCu);
    for (int i = 0; i < 4; i++) begin
      bus.command_in[i].valid   = valid[i];
      bus.command_in[i].cu_id   = 8'(1 + i);
      bus.command_in[i].address = 32'hA000_0000 + 32'(i);
      bus.command_in[i].size    = 8'd64;
    end
    bus.read_buffer_status.alfull = alfull;
    bus.read_buffer_status.full   = 1'b0;
    bus.read_buffer_status.empty  = 1'b0;
    bus.read_response_in.valid     = rspV;
    bus.read_response_in.cmd.cu_id = rspCu;
    bus.read_response_in.cmd.tag   = 8'd0;
    bus.read_response_in.data      = 32'd0;
  endtask

  task automatic applyLimStimulus(input logic [3:0] valid, input logic rspV, input logic [7:0] rspCu);
    for (int i = 0; i < 4; i++) begin
      busL.command_in[i].valid   = valid[i];
      busL.command_in[i].cu_id   = 8'(1 + i);
      busL.command_in[i].address = 32'hB000_0000 + 32'(i);
      busL.command_in[i].size    = 8'd64;
    end
    busL.read_buffer_status = '0;
    busL.read_response_in.valid     = rspV;
    busL.read_response_in.cmd.cu_id = rspCu;
    busL.read_response_in.cmd.tag   = 8'd0;
    busL.read_response_in.data      = 32'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, 8'd0);
    tick();
    rstn = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'hF, 1'b0, 1'b0, 8'd0, 4'h1, 1'b1, 32'hA000_0000, 4'h0, 1'b0, 32'h0000_0001};
    vecs[1]  = '{4'hF, 1'b0, 1'b0, 8'd0, 4'h2, 1'b1, 32'hA000_0001, 4'h0, 1'b0, 32'h0000_0101};
    vecs[2]  = '{4'hF, 1'b0, 1'b0, 8'd0, 4'h4, 1'b1, 32'hA000_0002, 4'h0, 1'b0, 32'h0001_0101};
    vecs[3]  = '{4'hF, 1'b0, 1'b0, 8'd0, 4'h8, 1'b1, 32'hA000_0003, 4'h0, 1'b0, 32'h0101_0101};
    vecs[4]  = '{4'h5, 1'b1, 1'b0, 8'd0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0101_0101};
    vecs[5]  = '{4'h5, 1'b1, 1'b0, 8'd0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0101_0101};
    vecs[6]  = '{4'h5, 1'b1, 1'b0, 8'd0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0101_0101};
    vecs[7]  = '{4'h5, 1'b1, 1'b0, 8'd0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0101_0101};
    vecs[8]  = '{4'h5, 1'b1, 1'b0, 8'd0, 4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0101_0101};
    vecs[9]  = '{4'h5, 1'b0, 1'b0, 8'd0, 4'h1, 1'b1, 32'hA000_0000, 4'h0, 1'b0, 32'h0101_0102};
    vecs[10] = '{4'h5, 1'b0, 1'b0, 8'd0, 4'h4, 1'b1, 32'hA000_0002, 4'h0, 1'b0, 32'h0102_0102};
    vecs[11] = '{4'h0, 1'b0, 1'b1, 8'd1, 4'h0, 1'b0, 32'h0,        4'h1, 1'b0, 32'h0102_0101};
    vecs[12] = '{4'h0, 1'b0, 1'b1, 8'd9, 4'h0, 1'b0, 32'h0,        4'h0, 1'b1, 32'h0102_0101};
    vecs[13] = '{4'h8, 1'b0, 1'b1, 8'd4, 4'h8, 1'b1, 32'hA000_0003, 4'h8, 1'b1, 32'h0102_0101};

    rstn     = 1'b1;
    enabled  = 1'b1;
    drainReq = 1'b0;
    applyStimulus(4'h0, 1'b0, 1'b0, 8'd0);
    applyLimStimulus(4'h0, 1'b0, 8'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset command_out", 64'(bus.command_out), 64'd0);
    checkOutput("reset grant", 64'(bus.grant_out), 64'd0);
    checkOutput("reset response_valid", 64'(bus.response_valid_out), 64'd0);
    checkOutput("reset outstanding", 64'(bus.outstanding_out), 64'd0);
    checkOutput("reset drain_done", 64'(drainDone), 64'd0);
    checkOutput("reset error", 64'(errorOut), 64'd0);

    // First cycle out of reset sits in ARB_RESET, so no grant yet.
    rstn = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b0, 8'd0);
    #1;
    checkOutput("grant in ARB_RESET", 64'(bus.grant_out), 64'd0);
    tick();

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].alfull, vecs[v].rspV, vecs[v].rspCu);
      #1;
      checkOutput($sformatf("vec%0d grant", v), 64'(bus.grant_out), 64'(vecs[v].expGrant));
      tick();
      checkOutput($sformatf("vec%0d cmd valid", v), 64'(bus.command_out.valid), 64'(vecs[v].expCmdV));
      if (vecs[v].expCmdV)
        checkOutput($sformatf("vec%0d cmd addr", v), 64'(bus.command_out.address), 64'(vecs[v].expAddr));
      checkOutput($sformatf("vec%0d rsp valid", v), 64'(bus.response_valid_out), 64'(vecs[v].expRsp));
      checkOutput($sformatf("vec%0d error", v), 64'(errorOut), 64'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d outstanding", v), 64'(bus.outstanding_out), 64'(vecs[v].expCnt));
    end

    // Raise port 3 from 1 to 5, then grant and respond on it in the same cycle.
    for (int n = 0; n < 4; n++) begin
      applyStimulus(4'h8, 1'b0, 1'b0, 8'd0);
      #1;
      checkOutput("port3 fill grant", 64'(bus.grant_out), 64'h8);
      tick();
    end
    checkOutput("port3 count 5", 64'(bus.outstanding_out[3]), 64'd5);
    applyStimulus(4'h8, 1'b0, 1'b1, 8'd4);
    #1;
    checkOutput("same-cycle grant", 64'(bus.grant_out), 64'h8);
    tick();
    checkOutput("same-cycle count", 64'(bus.outstanding_out[3]), 64'd5);
    checkOutput("same-cycle rsp valid", 64'(bus.response_valid_out), 64'h8);

    enabled = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b1, 8'd1);
    #1;
    checkOutput("disabled grant", 64'(bus.grant_out), 64'd0);
    tick();
    checkOutput("disabled counts hold", 64'(bus.outstanding_out), 64'h0502_0101);
    enabled = 1'b1;

    doReset();
    checkOutput("reset clears error", 64'(errorOut), 64'd0);
    checkOutput("reset clears counts", 64'(bus.outstanding_out), 64'd0);
    applyStimulus(4'h0, 1'b0, 1'b1, 8'd2);
    tick();
    checkOutput("zero-count error", 64'(errorOut), 64'd1);
    checkOutput("zero-count no underflow", 64'(bus.outstanding_out), 64'd0);
    checkOutput("zero-count rsp dropped", 64'(bus.response_valid_out), 64'd0);
    doReset();
    checkOutput("reset clears error again", 64'(errorOut), 64'd0);

    // Drain with three reads in flight on ports 0..2.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(4'h7, 1'b0, 1'b0, 8'd0);
      #1;
      checkOutput($sformatf("drain setup grant%0d", n), 64'(bus.grant_out), 64'(4'h1 << n));
      tick();
    end
    drainReq = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'hF, 1'b0, (c == 2) || (c == 5) || (c == 9),
                    (c == 2) ? 8'd1 : (c == 5) ? 8'd2 : 8'd3);
      #1;
      checkOutput($sformatf("drain c%0d grant", c), 64'(bus.grant_out), 64'd0);
      tick();
      checkOutput($sformatf("drain c%0d done", c), 64'(drainDone), 64'd0);
    end
    checkOutput("drain counts empty", 64'(bus.outstanding_out), 64'd0);
    applyStimulus(4'hF, 1'b0, 1'b0, 8'd0);
    #1;
    checkOutput("drain idle grant", 64'(bus.grant_out), 64'd0);
    tick();
    checkOutput("drain_done rises", 64'(drainDone), 64'd1);
    drainReq = 1'b0;
    #1;
    checkOutput("grant in ARB_DONE", 64'(bus.grant_out), 64'd0);
    tick();
    checkOutput("drain_done falls", 64'(drainDone), 64'd0);
    #1;
    checkOutput("resume grant", 64'(bus.grant_out), 64'h8);
    applyStimulus(4'h0, 1'b0, 1'b0, 8'd0);

    // In-flight limit of 2 on the second instance, port 1 only.
    for (int n = 0; n < 4; n++) begin
      applyLimStimulus(4'h2, 1'b0, 8'd0);
      #1;
      checkOutput($sformatf("limit grant%0d", n), 64'(busL.grant_out), (n < 2) ? 64'h2 : 64'h0);
      tick();
    end
    checkOutput("limit count", 64'(busL.outstanding_out[1]), 64'd2);
    applyLimStimulus(4'h2, 1'b1, 8'd2);
    #1;
    checkOutput("limit grant during rsp", 64'(busL.grant_out), 64'd0);
    tick();
    checkOutput("limit count after rsp", 64'(busL.outstanding_out[1]), 64'd1);
    checkOutput("limit rsp valid", 64'(busL.response_valid_out), 64'h2);
    applyLimStimulus(4'h2, 1'b0, 8'd0);
    #1;
    checkOutput("limit eligible again", 64'(busL.grant_out), 64'h2);
    tick();
    checkOutput("limit count refilled", 64'(busL.outstanding_out[1]), 64'd2);
    applyLimStimulus(4'h0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
